pokey_audio_sequencer: RTL and testbench

- Pattern-driven controller that owns the AUDF1-4/AUDC1-4/AUDCTL register bank feeding pokeyaudio; replaces static DIP-switch tone configuration.
- Host (switch/CPU glue) loads a step pattern RAM, then issues start; the block writes channel registers step by step, holding each step for a programmed number of frame ticks derived from clk179.
- Supports chords (zero-duration steps), looping, stop/silence, and a done pulse.

---
 rtl/pokey_audio_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_pokey_audio_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pokey_audio_sequencer.sv
`timescale 1ns/1ps
// Pattern-driven sequencer for the POKEY AUDF/AUDC/AUDCTL register bank.
// Steps come from a small synchronous RAM and are held for a number of frame ticks.
module pokey_audio_sequencer #(
  parameter int STEPS    = 16,
  parameter int TICK_DIV = 29830,
  localparam int AW = $clog2(STEPS),
  localparam int DW = $clog2(TICK_DIV + 1)
) (
  input  logic          clk179,
  input  logic          init,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  input  logic [AW:0]   len,
  input  logic          loop,
  input  logic [7:0]    audctl_in,
  input  logic          start,
  input  logic          stop,
  output logic [7:0]    AUDF1,
  output logic [7:0]    AUDF2,
  output logic [7:0]    AUDF3,
  output logic [7:0]    AUDF4,
  output logic [7:0]    AUDC1,
  output logic [7:0]    AUDC2,
  output logic [7:0]    AUDC3,
  output logic [7:0]    AUDC4,
  output logic [7:0]    AUDCTL,
  output logic          busy,
  output logic [AW-1:0] step_idx,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, FETCH, APPLY, HOLD} state_t;

  localparam logic [AW:0]   STEPS_W = (AW+1)'(STEPS);
  localparam logic [DW-1:0] DIV_TOP = DW'(TICK_DIV - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   len_q, len_d;
  logic          loop_q, loop_d;
  logic [5:0]    hold_q, hold_d;
  logic [DW-1:0] div_q, div_d;
  logic [7:0]    audf_q [4];
  logic [7:0]    audf_d [4];
  logic [7:0]    audc_q [4];
  logic [7:0]    audc_d [4];
  logic [7:0]    audctl_q, audctl_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [23:0]   mem [STEPS];
  logic [23:0]   ram_rd_q;

  logic          tick;
  logic          last_step;
  logic          advance;
  logic          silence;
  logic [1:0]    step_chan;
  logic [5:0]    step_dur;

  assign tick      = (div_q == DIV_TOP);
  assign last_step = ({1'b0, idx_q} == (len_q - 1'b1));
  assign step_chan = ram_rd_q[23:22];
  assign step_dur  = ram_rd_q[21:16];

  // Pattern RAM is write-protected while a pattern is playing.
  always_ff @(posedge clk179) begin
    if (wr_en && (state_q == IDLE)) mem[wr_addr] <= wr_data;
    ram_rd_q <= mem[idx_q];
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    loop_d   = loop_q;
    hold_d   = hold_q;
    div_d    = tick ? '0 : div_q + 1'b1;
    audf_d   = audf_q;
    audc_d   = audc_q;
    audctl_d = audctl_in;
    done_d   = 1'b0;
    advance  = 1'b0;
    silence  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop && (len != '0)) begin
          len_d   = (len > STEPS_W) ? STEPS_W : len;
          loop_d  = loop;
          idx_d   = '0;
          div_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = APPLY;
      APPLY: begin
        audf_d[step_chan] = ram_rd_q[15:8];
        audc_d[step_chan] = ram_rd_q[7:0];
        if (step_dur != 6'd0) begin
          hold_d  = step_dur;
          state_d = HOLD;
        end else begin
          advance = 1'b1;
        end
      end
      HOLD: begin
        if (tick) begin
          if (hold_q == 6'd1) advance = 1'b1;
          else                hold_d  = hold_q - 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (!last_step) begin
        idx_d   = idx_q + 1'b1;
        state_d = FETCH;
      end else if (loop_q) begin
        idx_d   = '0;
        state_d = FETCH;
      end else begin
        silence = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end

    // An abort overrides whatever the current step would have done.
    if (stop && (state_q != IDLE)) begin
      state_d = IDLE;
      idx_d   = idx_q;
      hold_d  = hold_q;
      audf_d  = audf_q;
      audc_d  = audc_q;
      done_d  = 1'b0;
      silence = 1'b1;
    end

    if (silence) begin
      for (int ch = 0; ch < 4; ch++) audc_d[ch][3:0] = 4'h0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk179 or posedge init) begin
    if (init) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      loop_q   <= 1'b0;
      hold_q   <= '0;
      div_q    <= '0;
      audf_q   <= '{default: 8'h00};
      audc_q   <= '{default: 8'h00};
      audctl_q <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      loop_q   <= loop_d;
      hold_q   <= hold_d;
      div_q    <= div_d;
      audf_q   <= audf_d;
      audc_q   <= audc_d;
      audctl_q <= audctl_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign AUDF1    = audf_q[0];
  assign AUDF2    = audf_q[1];
  assign AUDF3    = audf_q[2];
  assign AUDF4    = audf_q[3];
  assign AUDC1    = audc_q[0];
  assign AUDC2    = audc_q[1];
  assign AUDC3    = audc_q[2];
  assign AUDC4    = audc_q[3];
  assign AUDCTL   = audctl_q;
  assign busy     = busy_q;
  assign step_idx = idx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_pokey_audio_sequencer.sv
`timescale 1ns/1ps
// Bench for pokey_audio_sequencer (TICK_DIV shortened to 4). Expected outputs come
// from a per-step schedule: apply edges and tick-counted hold end edges.
module tb_pokey_audio_sequencer;

  localparam int STEPS    = 16;
  localparam int TICK_DIV = 4;
  localparam int AW       = 4;

  logic          clk179    = 1'b0;
  logic          init      = 1'b1;
  logic          wr_en     = 1'b0;
  logic [AW-1:0] wr_addr   = '0;
  logic [23:0]   wr_data   = '0;
  logic [AW:0]   len       = '0;
  logic          loop      = 1'b0;
  logic [7:0]    audctl_in = '0;
  logic          start     = 1'b0;
  logic          stop      = 1'b0;
  logic [7:0]    AUDF1, AUDF2, AUDF3, AUDF4;
  logic [7:0]    AUDC1, AUDC2, AUDC3, AUDC4;
  logic [7:0]    AUDCTL;
  logic          busy;
  logic [AW-1:0] step_idx;
  logic          done;

  int compared   = 0;
  int mismatched = 0;

  logic [23:0]   pat [STEPS];
  logic [7:0]    m_audf [4];
  logic [7:0]    m_audc [4];
  logic [7:0]    m_audctl;
  logic          m_busy;
  logic          m_done;
  logic [AW-1:0] m_idx;

  pokey_audio_sequencer #(.STEPS(STEPS), .TICK_DIV(TICK_DIV)) dut (
    .clk179(clk179), .init(init), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len(len), .loop(loop), .audctl_in(audctl_in), .start(start), .stop(stop),
    .AUDF1(AUDF1), .AUDF2(AUDF2), .AUDF3(AUDF3), .AUDF4(AUDF4),
    .AUDC1(AUDC1), .AUDC2(AUDC2), .AUDC3(AUDC3), .AUDC4(AUDC4),
    .AUDCTL(AUDCTL), .busy(busy), .step_idx(step_idx), .done(done)
  );

  always #5 clk179 = ~clk179;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".busy"}, {31'b0, busy}, {31'b0, m_busy});
    checkOutput({tag, ".done"}, {31'b0, done}, {31'b0, m_done});
    checkOutput({tag, ".step_idx"}, {28'b0, step_idx}, {28'b0, m_idx});
    checkOutput({tag, ".audf"}, {AUDF1, AUDF2, AUDF3, AUDF4}, {m_audf[0], m_audf[1], m_audf[2], m_audf[3]});
    checkOutput({tag, ".audc"}, {AUDC1, AUDC2, AUDC3, AUDC4}, {m_audc[0], m_audc[1], m_audc[2], m_audc[3]});
    checkOutput({tag, ".audctl"}, {24'b0, AUDCTL}, {24'b0, m_audctl});
  endtask

  task automatic modelReset();
    for (int c = 0; c < 4; c++) begin
      m_audf[c] = 8'h00;
      m_audc[c] = 8'h00;
    end
    m_audctl = 8'h00;
    m_busy   = 1'b0;
    m_done   = 1'b0;
    m_idx    = '0;
  endtask

  task automatic modelSilence();
    for (int c = 0; c < 4; c++) m_audc[c][3:0] = 4'h0;
  endtask

  // One clock edge with a fresh random AUDCTL input; sampling happens 1 ns later.
  task automatic tickEdge();
    logic [7:0] a;
    a = 8'($urandom);
    audctl_in = a;
    @(posedge clk179);
    #1;
    m_audctl = a;
  endtask

  task automatic loadStep(input int addr, input logic [23:0] word);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = word;
    tickEdge();
    wr_en = 1'b0;
    pat[addr] = word;
  endtask

  function automatic logic [23:0] mkStep(input int ch, input int dur, input logic [7:0] f, input logic [7:0] c);
    return {2'(ch), 6'(dur), f, c};
  endfunction

  task automatic idleCheck(input string tag);
    tickEdge();
    m_done = 1'b0;
    checkAll(tag);
  endtask

  // Plays one pattern from IDLE; optionally aborts or resets once stopAfter/resetAfter
  // steps have been applied and the sequencer is holding.
  task automatic applyStimulus(input string name, input logic [AW:0] l, input logic lp,
                               input int stopAfter, input int resetAfter,
                               input logic pokeBusy, input logic withStop);
    int         lv, lenEff, n, nextApply, endEdge, applies, curStep, m0, dur;
    logic       inHold, active, stopping;
    logic [23:0] w;
    lv     = int'(l);
    lenEff = (lv > STEPS) ? STEPS : lv;
    len    = l;
    loop   = lp;
    start  = 1'b1;
    stop   = withStop;
    tickEdge();
    start = 1'b0;
    stop  = 1'b0;
    len   = (AW+1)'($urandom);
    loop  = 1'($urandom);
    m_done = 1'b0;
    if (lv == 0 || withStop) begin
      checkAll({name, ".ignored"});
      idleCheck({name, ".ignored2"});
      return;
    end
    m_busy = 1'b1;
    m_idx  = '0;
    checkAll({name, ".start"});
    nextApply = 2; endEdge = -1; applies = 0; curStep = 0;
    inHold = 1'b0; active = 1'b1;
    n = 0;
    while (active && n < 3000) begin
      n++;
      if (resetAfter > 0 && applies >= resetAfter && inHold) begin
        #2 init = 1'b1;
        #1;
        modelReset();
        checkAll({name, ".async_reset"});
        #1 init = 1'b0;
        return;
      end
      stop = (stopAfter > 0 && applies >= stopAfter && inHold);
      if (pokeBusy && n == 3) begin
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = 24'($urandom);
      end
      tickEdge();
      stopping = stop;
      stop  = 1'b0;
      wr_en = 1'b0;
      m_done = 1'b0;
      if (stopping) begin
        modelSilence();
        m_busy = 1'b0;
        active = 1'b0;
        checkAll($sformatf("%s.stop@%0d", name, n));
        break;
      end
      if (n == nextApply) begin
        w = pat[curStep];
        m_audf[w[23:22]] = w[15:8];
        m_audc[w[23:22]] = w[7:0];
        applies++;
        dur = int'(w[21:16]);
        if (dur == 0) endEdge = n;
        else begin
          m0      = n + (TICK_DIV - 1 - (n % TICK_DIV));
          endEdge = m0 + TICK_DIV * (dur - 1) + 1;
          inHold  = 1'b1;
        end
      end
      if (n == endEdge) begin
        inHold = 1'b0;
        if (curStep < lenEff - 1) begin
          curStep++;
          m_idx = AW'(curStep);
          nextApply = n + 2;
        end else if (lp) begin
          curStep = 0;
          m_idx = '0;
          nextApply = n + 2;
        end else begin
          modelSilence();
          m_done = 1'b1;
          m_busy = 1'b0;
          active = 1'b0;
        end
      end
      checkAll($sformatf("%s@%0d", name, n));
    end
    checkOutput({name, ".finished"}, {31'b0, active}, 32'd0);
    idleCheck({name, ".after"});
  endtask

  initial begin
    int         nl, dl;
    logic       lp;
    modelReset();
    for (int i = 0; i < STEPS; i++) pat[i] = '0;
    #12;
    checkAll("reset");
    #3 init = 1'b0;
    #1;
    for (int i = 0; i < STEPS; i++) loadStep(i, 24'h0);
    idleCheck("idle");

    loadStep(0, mkStep(0, 2, 8'h40, 8'hA8));
    applyStimulus("single", 5'd1, 1'b0, 0, 0, 1'b0, 1'b0);
    $display("[TB] single note: AUDC1=%h", AUDC1);

    loadStep(0, mkStep(0, 0, 8'h10, 8'h21));
    loadStep(1, mkStep(1, 0, 8'h20, 8'h42));
    loadStep(2, mkStep(2, 3, 8'h30, 8'h63));
    applyStimulus("chord", 5'd3, 1'b0, 0, 0, 1'b0, 1'b0);

    applyStimulus("len0", 5'd0, 1'b0, 0, 0, 1'b0, 1'b0);
    applyStimulus("startstop", 5'd2, 1'b0, 0, 0, 1'b0, 1'b1);

    loadStep(0, mkStep(0, 1, 8'h11, 8'hC5));
    loadStep(1, mkStep(3, 1, 8'h22, 8'hD7));
    applyStimulus("loopwrap", 5'd2, 1'b1, 5, 0, 1'b0, 1'b0);

    loadStep(0, mkStep(1, 1, 8'h55, 8'h8F));
    applyStimulus("wrprotect", 5'd1, 1'b0, 0, 0, 1'b1, 1'b0);
    loadStep(0, mkStep(2, 1, 8'h66, 8'h9E));
    applyStimulus("rewrite", 5'd1, 1'b0, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < STEPS; i++)
      loadStep(i, mkStep($urandom_range(0, 3), $urandom_range(0, 1), 8'($urandom), 8'($urandom)));
    applyStimulus("len31", 5'd31, 1'b0, 0, 0, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      nl = $urandom_range(1, STEPS);
      lp = 1'($urandom);
      for (int i = 0; i < nl; i++) begin
        dl = (i == 0) ? $urandom_range(1, 3) : $urandom_range(0, 3);
        loadStep(i, mkStep($urandom_range(0, 3), dl, 8'($urandom), 8'($urandom)));
      end
      applyStimulus($sformatf("rand%0d", r), 5'(nl), lp,
                    lp ? $urandom_range(1, 2 * nl) : 0, 0, 1'b0, 1'b0);
    end

    loadStep(0, mkStep(3, 3, 8'hE1, 8'hFF));
    applyStimulus("midreset", 5'd1, 1'b0, 0, 1, 1'b0, 1'b0);
    idleCheck("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
